// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl
// Time-multiplexing controller for a 4-digit, common-anode seven-segment
// display. A 16-bit display word is shown one hex nibble per digit slot.
// Digit 0 is the rightmost digit. New words land in a shadow register and
// are committed to the live word only at frame boundaries, so a frame
// never mixes old and new digits.
//
// Parameters
//   TICK_DIV  clock cycles per digit slot (>= 2)
//   GUARD     dark cycles at the start of each slot (0 <= GUARD < TICK_DIV)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      scan enable (registered into en_q)
//   load        one-cycle strobe: capture value into the shadow register
//   value       16-bit word to display; nibble k drives digit k
//   blank_lz    leading-zero blanking enable (registered)
//   digit       nibble for the current slot, to the hex-to-segment decoder
//   an          active-low one-hot anodes; 4'b1111 means all off
//   frame_done  one-cycle pulse on the edge where slot wraps 3 -> 0
//   pending     shadow holds a value that has not been committed yet
module ssd_scan_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int GUARD    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        pending
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       slot_reg, slot_next;
  logic [15:0]      disp_reg, disp_next;
  logic [15:0]      shadow_reg, shadow_next;
  logic             pending_reg, pending_next;
  logic             en_q_reg;
  logic             blank_q_reg;
  logic             frame_done_reg, frame_done_next;

  logic tick;
  logic wrap;
  logic commit;

  assign tick = en_q_reg && (cnt_reg == CNT_MAX);
  assign wrap = tick && (slot_reg == 2'd3);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      slot_reg       <= '0;
      disp_reg       <= '0;
      shadow_reg     <= '0;
      pending_reg    <= 1'b0;
      en_q_reg       <= 1'b0;
      blank_q_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      slot_reg       <= slot_next;
      disp_reg       <= disp_next;
      shadow_reg     <= shadow_next;
      pending_reg    <= pending_next;
      en_q_reg       <= enable;
      // blank_lz is registered like enable so every output decodes
      // registers only; blanking mode changes take effect one cycle later.
      blank_q_reg    <= blank_lz;
      frame_done_reg <= frame_done_next;
    end
  end

  // Next-state logic
  always_comb begin
    cnt_next        = '0;
    slot_next       = '0;
    frame_done_next = 1'b0;
    disp_next       = disp_reg;
    shadow_next     = shadow_reg;
    pending_next    = pending_reg;
    commit          = 1'b0;

    if (en_q_reg) begin
      if (tick) begin
        cnt_next  = '0;
        slot_next = slot_reg + 2'd1;
      end else begin
        cnt_next  = cnt_reg + CNT_W'(1);
        slot_next = slot_reg;
      end
      frame_done_next = wrap;
      commit          = wrap && pending_reg;
    end else begin
      // Not scanning, so there is no frame to tear: commit right away.
      commit = pending_reg;
    end

    // The commit moves the pre-edge shadow into disp.
    if (commit) begin
      disp_next    = shadow_reg;
      pending_next = 1'b0;
    end

    // A load on the same edge wins for shadow and pending.
    if (load) begin
      shadow_next  = value;
      pending_next = 1'b1;
    end
  end

  // Nibble split and leading-zero detection
  logic [3:0] nib [4];
  logic [3:0] nib_zero;
  logic [3:0] zero_from;   // zero_from[k]: nibbles k..3 are all zero

  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    assign nib[gi]      = disp_reg[4*gi +: 4];
    assign nib_zero[gi] = (disp_reg[4*gi +: 4] == 4'h0);
  end

  assign zero_from[3] = nib_zero[3];
  for (genvar gi = 0; gi < 3; gi++) begin : g_zero_from
    assign zero_from[gi] = nib_zero[gi] & zero_from[gi+1];
  end

  // Anti-ghosting guard window at the start of each slot.
  logic guard_on;
  if (GUARD == 0) begin : g_no_guard
    assign guard_on = 1'b0;
  end else begin : g_guard
    assign guard_on = (cnt_reg < CNT_W'(GUARD));
  end

  // Digit 0 is never blanked so an all-zero word still shows one "0".
  logic lz_blank;
  assign lz_blank = blank_q_reg && (slot_reg != 2'd0) && zero_from[slot_reg];

  // Outputs
  assign digit      = nib[slot_reg];
  assign an         = (!en_q_reg || guard_on || lz_blank) ? 4'b1111
                                                          : ~(4'b0001 << slot_reg);
  assign frame_done = frame_done_reg;
  assign pending    = pending_reg;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed testbench for ssd_scan_ctrl with TICK_DIV=4, GUARD=1.
// Inputs are driven and outputs sampled on the falling clock edge.
// Scan position i counts falling edges after en_q rises:
// cnt = i % 4 and slot = (i / 4) % 4.
module tb_ssd_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  int n_cmp;
  int n_fail;

  ssd_scan_ctrl #(.TICK_DIV(4), .GUARD(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .digit      (digit),
    .an         (an),
    .frame_done (frame_done),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helper: stop scanning, then load and commit a word while disabled.
  task automatic stop_and_load(input logic [15:0] w);
    enable = 1'b0;
    @(negedge clk);
    load  = 1'b1;
    value = w;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("load %h committed while disabled", w);
  endtask

  // Stimulus helper: enable scanning; returns at scan position i=0.
  task automatic start_scan();
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    enable   = 1'b1;
    load     = 1'b1;
    value    = 16'hFFFF;
    blank_lz = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", an); end
      n_cmp++;
      if (digit !== 4'h0) begin n_fail++; $display("FAIL reset_digit: got %h expected 0", digit); end
      n_cmp++;
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
      n_cmp++;
      if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0", pending); end
      value = value ^ 16'h5A5A;
      load  = ~load;
    end
    enable   = 1'b0;
    load     = 1'b0;
    value    = 16'h0000;
    blank_lz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset sequence done");
  endtask

  task automatic test_scan();
    logic [15:0] w;
    logic [3:0]  exp_an;
    logic [3:0]  exp_dig;
    logic        exp_fd;
    int          s;
    int          c;
    w = 16'h1234;
    enable = 1'b0;
    @(negedge clk);
    load  = 1'b1;
    value = w;
    @(negedge clk);
    load = 1'b0;
    n_cmp++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL scan_load_pending: got %b expected 1", pending); end
    @(negedge clk);
    n_cmp++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL scan_commit_pending: got %b expected 0", pending); end
    n_cmp++;
    if (digit !== 4'h4) begin n_fail++; $display("FAIL scan_commit_digit: got %h expected 4", digit); end
    n_cmp++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL scan_disabled_an: got %b expected 1111", an); end
    start_scan();
    for (int i = 0; i < 33; i++) begin
      s = (i / 4) % 4;
      c = i % 4;
      exp_an  = (c < 1) ? 4'b1111 : ~(4'b0001 << s);
      exp_dig = w[4*s +: 4];
      exp_fd  = (i > 0) && (i % 16 == 0);
      n_cmp++;
      if (an !== exp_an) begin n_fail++; $display("FAIL scan_an i=%0d: got %b expected %b", i, an, exp_an); end
      n_cmp++;
      if (digit !== exp_dig) begin n_fail++; $display("FAIL scan_digit i=%0d: got %h expected %h", i, digit, exp_dig); end
      n_cmp++;
      if (frame_done !== exp_fd) begin n_fail++; $display("FAIL scan_frame_done i=%0d: got %b expected %b", i, frame_done, exp_fd); end
      @(negedge clk);
    end
    $display("scan of %h done", w);
  endtask

  task automatic test_leading_zeros();
    logic [15:0] words [3];
    logic        blanks [3];
    logic [3:0]  lit [3];
    logic [15:0] w;
    logic [3:0]  lm;
    logic [3:0]  exp_an;
    logic [3:0]  exp_dig;
    int          s;
    int          c;
    words[0] = 16'h0050; blanks[0] = 1'b1; lit[0] = 4'b0011;
    words[1] = 16'h0000; blanks[1] = 1'b1; lit[1] = 4'b0001;
    words[2] = 16'h0000; blanks[2] = 1'b0; lit[2] = 4'b1111;
    for (int t = 0; t < 3; t++) begin
      w  = words[t];
      lm = lit[t];
      blank_lz = blanks[t];
      stop_and_load(w);
      start_scan();
      for (int i = 0; i < 16; i++) begin
        s = i / 4;
        c = i % 4;
        exp_an  = (c < 1 || !lm[s]) ? 4'b1111 : ~(4'b0001 << s);
        exp_dig = w[4*s +: 4];
        n_cmp++;
        if (an !== exp_an) begin n_fail++; $display("FAIL lz_an case=%0d i=%0d: got %b expected %b", t, i, an, exp_an); end
        n_cmp++;
        if (digit !== exp_dig) begin n_fail++; $display("FAIL lz_digit case=%0d i=%0d: got %h expected %h", t, i, digit, exp_dig); end
        @(negedge clk);
      end
      $display("leading-zero case %0d (word %h, blank_lz %b) done", t, w, blanks[t]);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_tear_free();
    logic [15:0] w;
    logic [3:0]  exp_dig;
    logic        exp_pend;
    int          s;
    // Load mid-frame: shows only from the next frame.
    stop_and_load(16'h1234);
    start_scan();
    for (int i = 0; i < 32; i++) begin
      s        = (i / 4) % 4;
      w        = (i < 16) ? 16'h1234 : 16'hAAAA;
      exp_dig  = w[4*s +: 4];
      exp_pend = (i >= 6) && (i < 16);
      n_cmp++;
      if (digit !== exp_dig) begin n_fail++; $display("FAIL tear1_digit i=%0d: got %h expected %h", i, digit, exp_dig); end
      n_cmp++;
      if (pending !== exp_pend) begin n_fail++; $display("FAIL tear1_pending i=%0d: got %b expected %b", i, pending, exp_pend); end
      if (i == 16) begin
        n_cmp++;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL tear1_frame_done: got %b expected 1", frame_done); end
      end
      load  = (i == 5);
      value = 16'hAAAA;
      @(negedge clk);
    end
    load = 1'b0;
    $display("load AAAA in slot 1 done");

    // Load exactly on the wrap edge while CCCC is pending.
    stop_and_load(16'h1234);
    start_scan();
    for (int i = 0; i < 36; i++) begin
      s        = (i / 4) % 4;
      w        = (i < 16) ? 16'h1234 : ((i < 32) ? 16'hCCCC : 16'hBBBB);
      exp_dig  = w[4*s +: 4];
      exp_pend = (i >= 9) && (i < 32);
      n_cmp++;
      if (digit !== exp_dig) begin n_fail++; $display("FAIL tear2_digit i=%0d: got %h expected %h", i, digit, exp_dig); end
      n_cmp++;
      if (pending !== exp_pend) begin n_fail++; $display("FAIL tear2_pending i=%0d: got %b expected %b", i, pending, exp_pend); end
      load  = (i == 8) || (i == 15);
      value = (i == 15) ? 16'hBBBB : 16'hCCCC;
      @(negedge clk);
    end
    load = 1'b0;
    $display("load BBBB on wrap edge with CCCC pending done");
  endtask

  task automatic test_enable_drop();
    logic [3:0] exp_an;
    stop_and_load(16'h1234);
    start_scan();
    repeat (9) @(negedge clk);   // now at i=9: slot 2, lit
    n_cmp++;
    if (an !== 4'b1011) begin n_fail++; $display("FAIL drop_pre_an: got %b expected 1011", an); end
    enable = 1'b0;
    load   = 1'b1;
    value  = 16'h5678;
    @(negedge clk);
    load = 1'b0;
    n_cmp++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL drop_an1: got %b expected 1111", an); end
    n_cmp++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL drop_pending1: got %b expected 1", pending); end
    n_cmp++;
    if (digit !== 4'h2) begin n_fail++; $display("FAIL drop_digit1: got %h expected 2", digit); end
    n_cmp++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL drop_frame_done1: got %b expected 0", frame_done); end
    @(negedge clk);
    n_cmp++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL drop_an2: got %b expected 1111", an); end
    n_cmp++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL drop_pending2: got %b expected 0", pending); end
    n_cmp++;
    if (digit !== 4'h8) begin n_fail++; $display("FAIL drop_digit2: got %h expected 8", digit); end
    repeat (3) @(negedge clk);
    start_scan();
    for (int i = 0; i < 8; i++) begin
      exp_an = (i % 4 == 0) ? 4'b1111 : ~(4'b0001 << (i / 4));
      n_cmp++;
      if (an !== exp_an) begin n_fail++; $display("FAIL drop_restart_an i=%0d: got %b expected %b", i, an, exp_an); end
      @(negedge clk);
    end
    $display("enable drop with load 5678 done");
  endtask

  task automatic test_reset_midframe();
    stop_and_load(16'h1234);
    start_scan();
    repeat (8) @(negedge clk);   // i=8: slot 2, guard cycle
    load  = 1'b1;
    value = 16'h9999;
    @(negedge clk);              // i=9: slot 2, lit, 9999 pending
    load = 1'b0;
    n_cmp++;
    if (an !== 4'b1011) begin n_fail++; $display("FAIL rstmid_pre_an: got %b expected 1011", an); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL rstmid_an: got %b expected 1111", an); end
    n_cmp++;
    if (digit !== 4'h0) begin n_fail++; $display("FAIL rstmid_digit: got %h expected 0", digit); end
    n_cmp++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending: got %b expected 0", pending); end
    n_cmp++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_done: got %b expected 0", frame_done); end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // The discarded shadow must not reappear after reset.
    n_cmp++;
    if (digit !== 4'h0) begin n_fail++; $display("FAIL rstmid_post_digit: got %h expected 0", digit); end
    n_cmp++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL rstmid_post_pending: got %b expected 0", pending); end
    $display("reset mid-slot 2 done");
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    load     = 1'b0;
    value    = 16'h0000;
    blank_lz = 1'b0;
    test_reset();
    test_scan();
    test_leading_zeros();
    test_tear_free();
    test_enable_drop();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
